// File: rtl/tdc_edge_gen_pkg.sv
// -----------------------------------------------------------------------------
// tdc_edge_gen_pkg
// Shared definitions for the TDC start/stop edge generator and its readout
// counterpart: default field widths, the generator state encoding and a small
// width helper.
// -----------------------------------------------------------------------------
package tdc_edge_gen_pkg;

    // Default widths of the delay, gap and repeat configuration fields.
    localparam int DLY_W_DEF = 8;
    localparam int GAP_W_DEF = 8;
    localparam int RPT_W_DEF = 4;

    // Generator phases.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HI_START = 2'd1,
        ST_HI_BOTH  = 2'd2,
        ST_GAP      = 2'd3
    } gen_state_t;

    // The phase timer must hold either a delay or a gap reload value.
    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tdc_gen_timer.sv
// -----------------------------------------------------------------------------
// tdc_gen_timer
// Loadable down-counter with a zero flag. Shared by the HI_START and GAP
// phases of the edge generator: it is loaded with (length - 1) on entry to a
// phase and the phase ends in the cycle the counter reads zero.
//
// Ports
//   clk       in   1   system clock
//   rst_n     in   1   asynchronous active-low reset
//   load      in   1   load count_reg with load_val (has priority over dec)
//   load_val  in   W   reload value
//   dec       in   1   decrement; saturates at zero, never wraps
//   zero      out  1   count_reg is zero
// -----------------------------------------------------------------------------
module tdc_gen_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - W'(1);
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/tdc_edge_gen.sv
// -----------------------------------------------------------------------------
// tdc_edge_gen
// Digital stimulus source for the TDC. On a trigger rising edge it emits a
// burst of repeat_i+1 START/STOP rising-edge pairs. STOP rises delay_i cycles
// after START; both fall together one cycle after STOP rises, then stay low
// for max(gap_i,1) cycles before the next pair.
//
// Ports
//   clk         in   1        system clock
//   rst_n       in   1        asynchronous active-low reset
//   ena         in   1        tile enable; low forces an abort
//   trig_i      in   1        burst request (rising edge while idle)
//   abort_i     in   1        synchronous abort, highest priority
//   delay_i     in   DLY_W    START->STOP separation in cycles
//   gap_i       in   GAP_W    low time between pairs (0 behaves as 1)
//   repeat_i    in   RPT_W    pairs per burst minus one
//   start_o     out  1        START edge, straight from a flop
//   stop_o      out  1        STOP edge, straight from a flop
//   busy_o      out  1        burst in progress
//   done_o      out  1        one-cycle pulse on normal burst completion
//   pair_cnt_o  out  RPT_W+1  pairs completed since the last accept
// -----------------------------------------------------------------------------
module tdc_edge_gen
    import tdc_edge_gen_pkg::*;
#(
    parameter int DLY_W = DLY_W_DEF,
    parameter int GAP_W = GAP_W_DEF,
    parameter int RPT_W = RPT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             trig_i,
    input  logic             abort_i,
    input  logic [DLY_W-1:0] delay_i,
    input  logic [GAP_W-1:0] gap_i,
    input  logic [RPT_W-1:0] repeat_i,
    output logic             start_o,
    output logic             stop_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [RPT_W:0]   pair_cnt_o
);

    localparam int TMR_W = max_w(DLY_W, GAP_W);

    gen_state_t       state_reg, state_next;
    logic             trig_q_reg;
    logic [DLY_W-1:0] dly_reg;
    logic [GAP_W-1:0] gap_reg;
    logic [RPT_W-1:0] rpt_reg;
    logic [RPT_W:0]   pair_cnt_reg;
    logic             start_reg, stop_reg, busy_reg, done_reg;

    logic             abort_any;
    logic             accept;
    logic             last_pair;
    logic [GAP_W-1:0] gap_eff;
    logic [TMR_W-1:0] dly_in_m1, dly_m1, gap_m1;

    logic             tmr_load, tmr_dec, tmr_zero;
    logic [TMR_W-1:0] tmr_load_val;

    assign abort_any = abort_i | ~ena;
    assign accept    = (state_reg == ST_IDLE) & ~abort_any & trig_i & ~trig_q_reg;
    assign gap_eff   = (gap_i == '0) ? GAP_W'(1) : gap_i;

    // Timer reload values. The delay-1 forms are only used when the delay is
    // non-zero, and the latched gap is always at least 1, so none underflow.
    assign dly_in_m1 = TMR_W'(delay_i) - TMR_W'(1);
    assign dly_m1    = TMR_W'(dly_reg) - TMR_W'(1);
    assign gap_m1    = TMR_W'(gap_reg) - TMR_W'(1);

    // pair_cnt_reg still holds the count before the current HI_BOTH.
    assign last_pair = (pair_cnt_reg == {1'b0, rpt_reg});

    tdc_gen_timer #(
        .W(TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // Next-state decode.
    always_comb begin
        state_next   = state_reg;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_dec      = 1'b0;

        if (abort_any) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        if (delay_i == '0) begin
                            state_next = ST_HI_BOTH;
                        end else begin
                            state_next   = ST_HI_START;
                            tmr_load     = 1'b1;
                            tmr_load_val = dly_in_m1;
                        end
                    end
                end
                ST_HI_START: begin
                    if (tmr_zero) begin
                        state_next = ST_HI_BOTH;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                ST_HI_BOTH: begin
                    if (last_pair) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next   = ST_GAP;
                        tmr_load     = 1'b1;
                        tmr_load_val = gap_m1;
                    end
                end
                ST_GAP: begin
                    if (tmr_zero) begin
                        if (dly_reg == '0) begin
                            state_next = ST_HI_BOTH;
                        end else begin
                            state_next   = ST_HI_START;
                            tmr_load     = 1'b1;
                            tmr_load_val = dly_m1;
                        end
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // State, configuration and output flops. The outputs are decoded from
    // state_next so that each one comes straight off its own flop and carries
    // no combinational glitches into the TDC delay line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            trig_q_reg   <= 1'b1;   // a trigger already high at release is not an edge
            dly_reg      <= '0;
            gap_reg      <= GAP_W'(1);
            rpt_reg      <= '0;
            pair_cnt_reg <= '0;
            start_reg    <= 1'b0;
            stop_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg  <= state_next;
            trig_q_reg <= trig_i;
            start_reg  <= (state_next == ST_HI_START) || (state_next == ST_HI_BOTH);
            stop_reg   <= (state_next == ST_HI_BOTH);
            busy_reg   <= (state_next != ST_IDLE);
            done_reg   <= (state_reg == ST_HI_BOTH) && last_pair && !abort_any;

            if (accept) begin
                dly_reg      <= delay_i;
                gap_reg      <= gap_eff;
                rpt_reg      <= repeat_i;
                pair_cnt_reg <= '0;
            end else if (state_reg == ST_HI_BOTH) begin
                // A pair whose STOP edge was emitted counts even if aborted now.
                pair_cnt_reg <= pair_cnt_reg + (RPT_W+1)'(1);
            end
        end
    end

    assign start_o    = start_reg;
    assign stop_o     = stop_reg;
    assign busy_o     = busy_reg;
    assign done_o     = done_reg;
    assign pair_cnt_o = pair_cnt_reg;

endmodule
